// File: rtl/wrr_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wrr_scheduler_pkg
// Description : Shared sizing constants and FSM state encodings for the
//               weighted round-robin VC scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package wrr_scheduler_pkg;

    localparam int QUEUE_QUANTITY = 4;
    localparam int MAX_WEIGHT     = 64;
    localparam int WEIGHT_BITS    = $clog2(MAX_WEIGHT);
    localparam int SEL_BITS       = $clog2(QUEUE_QUANTITY);

    // Scheduler FSM encodings
    localparam logic [1:0] C_IDLE   = 2'd0;
    localparam logic [1:0] C_SELECT = 2'd1;
    localparam logic [1:0] C_SERVE  = 2'd2;

endpackage : wrr_scheduler_pkg
`default_nettype wire

// File: rtl/wrr_scheduler_rr_buscador.sv
`default_nettype none
// ============================================================================
// Module      : rr_buscador
// Description : Rotating-priority search. Starting just after i_ptr and
//               wrapping, returns the first set bit of i_eligible.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_buscador #(
    parameter int N_QUEUES   = 4,
    parameter int N_SEL_BITS = 2
) (
    input  logic [N_QUEUES-1:0]   i_eligible,
    input  logic [N_SEL_BITS-1:0] i_ptr,
    output logic [N_SEL_BITS-1:0] o_winner,
    output logic                  o_found
);

    // Walk offsets from farthest to nearest so the nearest eligible queue
    // after i_ptr is the last (and therefore winning) assignment.
    always_comb begin
        int w_idx;
        o_found  = 1'b0;
        o_winner = '0;
        w_idx    = 0;
        for (int k = N_QUEUES; k >= 1; k--) begin
            w_idx = (int'(i_ptr) + k) % N_QUEUES;
            if (i_eligible[w_idx]) begin
                o_found  = 1'b1;
                o_winner = N_SEL_BITS'(w_idx);
            end
        end
    end

endmodule : rr_buscador
`default_nettype wire

// File: rtl/wrr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : wrr_scheduler
// Description : Weighted round-robin scheduler draining VC FIFOs vc0..vc3
//               into the output FIFO. Each grant is a burst of up to the
//               queue's weight in words; one SELECT bubble between bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module wrr_scheduler
    import wrr_scheduler_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enb,
    input  logic [QUEUE_QUANTITY*WEIGHT_BITS-1:0] pesos,
    input  logic [QUEUE_QUANTITY-1:0]         buf_empty,
    input  logic                              salida_pausa,
    output logic [SEL_BITS-1:0]               selector,
    output logic                              selector_enb,
    output logic [QUEUE_QUANTITY-1:0]         grant,
    output logic                              idle
);

    localparam logic [WEIGHT_BITS-1:0] C_CREDIT_ONE = WEIGHT_BITS'(1);
    localparam logic [SEL_BITS-1:0]    C_PTR_RST    = SEL_BITS'(QUEUE_QUANTITY - 1);

    logic [1:0]                state_q,    state_d;
    logic [SEL_BITS-1:0]       selector_q, selector_d;
    logic [WEIGHT_BITS-1:0]    credit_q,   credit_d;
    logic [SEL_BITS-1:0]       ptr_q,      ptr_d;

    logic [QUEUE_QUANTITY-1:0] w_eligible;
    logic [SEL_BITS-1:0]       w_winner;
    logic                      w_found;
    logic [WEIGHT_BITS-1:0]    w_winner_weight;
    logic                      w_rd;
    logic                      w_sel_empty;

    // A queue competes only if it holds data and has a non-zero weight
    generate
        for (genvar gi = 0; gi < QUEUE_QUANTITY; gi++) begin : g_elig
            assign w_eligible[gi] = ~buf_empty[gi] &
                                    (pesos[gi*WEIGHT_BITS +: WEIGHT_BITS] != '0);
        end
    endgenerate

    rr_buscador #(
        .N_QUEUES   (QUEUE_QUANTITY),
        .N_SEL_BITS (SEL_BITS)
    ) u_buscador (
        .i_eligible (w_eligible),
        .i_ptr      (ptr_q),
        .o_winner   (w_winner),
        .o_found    (w_found)
    );

    assign w_winner_weight = pesos[w_winner*WEIGHT_BITS +: WEIGHT_BITS];
    assign w_sel_empty     = buf_empty[selector_q];

    // Read strobe reacts in the same cycle to empty/pause flags
    assign w_rd = (state_q == C_SERVE) & enb & ~w_sel_empty & ~salida_pausa;

    // Next-state, credit and rotation pointer; everything holds while enb=0
    always_comb begin
        state_d    = state_q;
        selector_d = selector_q;
        credit_d   = credit_q;
        ptr_d      = ptr_q;
        if (enb) begin
            case (state_q)
                C_IDLE: begin
                    if (|w_eligible) state_d = C_SELECT;
                end
                C_SELECT: begin
                    if (w_found) begin
                        selector_d = w_winner;
                        credit_d   = w_winner_weight;
                        state_d    = C_SERVE;
                    end else begin
                        state_d    = C_IDLE;
                    end
                end
                C_SERVE: begin
                    if (w_rd) credit_d = credit_q - C_CREDIT_ONE;
                    // Burst exhausted or queue drained: hand over, rotating
                    // the search origin to the queue just served.
                    if ((w_rd && credit_q == C_CREDIT_ONE) || w_sel_empty) begin
                        state_d = C_SELECT;
                        ptr_d   = selector_q;
                    end
                end
                default: state_d = C_IDLE;
            endcase
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= C_IDLE;
            selector_q <= '0;
            credit_q   <= '0;
            ptr_q      <= C_PTR_RST;
        end else begin
            state_q    <= state_d;
            selector_q <= selector_d;
            credit_q   <= credit_d;
            ptr_q      <= ptr_d;
        end
    end

    // One-hot grant only while a burst is in progress
    always_comb begin
        grant = '0;
        if (state_q == C_SERVE) grant[selector_q] = 1'b1;
    end

    assign selector     = selector_q;
    assign selector_enb = w_rd;
    assign idle         = (state_q == C_IDLE);

endmodule : wrr_scheduler
`default_nettype wire

// File: tb/tb_wrr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_wrr_scheduler
// Description : Directed self-checking bench for wrr_scheduler. A per-queue
//               word counter stands in for the VC FIFOs; each cycle the
//               packed {idle, selector_enb, grant} is compared against a
//               hand-computed vector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wrr_scheduler;

    logic        clk;
    logic        rst;
    logic        enb;
    logic [23:0] pesos;
    logic [3:0]  buf_empty;
    logic        salida_pausa;
    logic [1:0]  selector;
    logic        selector_enb;
    logic [3:0]  grant;
    logic        idle;

    int          cnt [4];
    int          n_cmp;
    int          n_err;
    int          pau_lo, pau_hi, enb_lo, enb_hi;
    logic [5:0]  exp_q [$];

    wrr_scheduler u_dut (
        .clk          (clk),
        .rst          (rst),
        .enb          (enb),
        .pesos        (pesos),
        .buf_empty    (buf_empty),
        .salida_pausa (salida_pausa),
        .selector     (selector),
        .selector_enb (selector_enb),
        .grant        (grant),
        .idle         (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pack_w(input int w0, input int w1, input int w2, input int w3);
        return {6'(w3), 6'(w2), 6'(w1), 6'(w0)};
    endfunction

    task automatic drive_empty();
        for (int q = 0; q < 4; q++) buf_empty[q] = (cnt[q] == 0);
    endtask

    // Assert reset, check the asynchronous reset values, release after an edge
    task automatic do_reset(input string name);
        rst = 1'b0;
        enb = 1'b1;
        salida_pausa = 1'b0;
        pesos = '0;
        for (int q = 0; q < 4; q++) cnt[q] = 0;
        buf_empty = 4'hF;
        pau_lo = -1; pau_hi = -2; enb_lo = -1; enb_hi = -2;
        #1;
        chk_val({name, "_rst_flags"}, {26'd0, idle, selector_enb, grant}, 32'h20);
        chk_val({name, "_rst_sel"}, {30'd0, selector}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Replay exp_q cycle by cycle; reads drain the modelled FIFOs
    task automatic run_seq(input string name);
        for (int i = 0; i < exp_q.size(); i++) begin
            enb          = !(i >= enb_lo && i <= enb_hi);
            salida_pausa = (i >= pau_lo && i <= pau_hi);
            drive_empty();
            #1;
            chk_val($sformatf("%s[%0d]", name, i),
                    {26'd0, idle, selector_enb, grant}, {26'd0, exp_q[i]});
            if (selector_enb && cnt[selector] > 0) cnt[selector]--;
            @(posedge clk);
            #1;
        end
        enb = 1'b1;
        salida_pausa = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        enb = 1'b1;
        salida_pausa = 1'b0;
        pesos = '0;
        buf_empty = 4'hF;
        #2;

        // Full rotation with q0 weight 2, others weight 1
        do_reset("rot");
        pesos = pack_w(2, 1, 1, 1);
        for (int q = 0; q < 4; q++) cnt[q] = 8;
        exp_q = {6'h20, 6'h00, 6'h11, 6'h11, 6'h00, 6'h12, 6'h00,
                 6'h14, 6'h00, 6'h18, 6'h00, 6'h11, 6'h11, 6'h00};
        run_seq("rot");

        // Sole queue q2, weight 3, 5 words: re-grant then drain to IDLE
        do_reset("sole");
        pesos = pack_w(1, 1, 3, 1);
        cnt[2] = 5;
        exp_q = {6'h20, 6'h00, 6'h14, 6'h14, 6'h14, 6'h00, 6'h14,
                 6'h14, 6'h04, 6'h00, 6'h20};
        run_seq("sole");
        chk_val("sole_cnt", 32'(cnt[2]), 32'd0);

        // Output pause for 3 cycles after the 2nd read of a weight-4 burst
        do_reset("pause");
        pesos = pack_w(0, 4, 0, 0);
        cnt[1] = 10;
        pau_lo = 4; pau_hi = 6;
        exp_q = {6'h20, 6'h00, 6'h12, 6'h12, 6'h02, 6'h02, 6'h02,
                 6'h12, 6'h12, 6'h00, 6'h12};
        run_seq("pause");

        // Weight 0 disables q0 even though it holds data
        do_reset("w0");
        pesos = pack_w(0, 2, 0, 0);
        cnt[0] = 10;
        cnt[1] = 10;
        exp_q = {6'h20, 6'h00, 6'h12, 6'h12, 6'h00, 6'h12, 6'h12,
                 6'h00, 6'h12};
        run_seq("w0");
        chk_val("w0_q0_cnt", 32'(cnt[0]), 32'd10);

        // Global enable low for 4 cycles mid-burst; remaining credit resumes
        do_reset("enb");
        pesos = pack_w(0, 0, 0, 4);
        cnt[3] = 10;
        enb_lo = 3; enb_hi = 6;
        exp_q = {6'h20, 6'h00, 6'h18, 6'h08, 6'h08, 6'h08, 6'h08,
                 6'h18, 6'h18, 6'h18, 6'h00};
        run_seq("enb");
        chk_val("enb_cnt", 32'(cnt[3]), 32'd6);

        // Asynchronous reset mid-SERVE (selector=2, credit=5)
        do_reset("arst");
        pesos = pack_w(0, 0, 5, 0);
        cnt[2] = 10;
        exp_q = {6'h20, 6'h00};
        run_seq("arst");
        drive_empty();
        #1;
        chk_val("arst_serve", {26'd0, idle, selector_enb, grant}, 32'h14);
        chk_val("arst_sel_pre", {30'd0, selector}, 32'h2);
        #2;
        rst = 1'b0;
        #1;
        chk_val("arst_flags", {26'd0, idle, selector_enb, grant}, 32'h20);
        chk_val("arst_sel", {30'd0, selector}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_wrr_scheduler
`default_nettype wire
